step_clock_gen: RTL and testbench

- Upstream of the single-cycle CPU top: produces the `cycle` stepping clock the CPU's PC and register file run on.
- Debounces a raw board pushbutton into exactly one clean `cycle` pulse per press (single-step mode).
- Alternatively free-runs `cycle` at a divided rate (run mode).
- Keeps a 5-bit step counter, which drives the `count` LEDs.

---
 rtl/step_clock_gen.sv | 155 +++++++++++++++
 tb/tb_step_clock_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// Stepping-clock generator for the single-cycle CPU.
// Turns a bouncing pushbutton into one clean `cycle` pulse per press, or
// free-runs `cycle` at a divided rate when run_en is set. `count` tallies
// rising edges of `cycle` modulo 32 for the LEDs.
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HIGH_CYCLES     = 4,
  parameter int unsigned RUN_HALF_PERIOD = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button,
  input  logic       run_en,
  output logic       cycle,
  output logic [4:0] count,
  output logic       busy
);

  localparam int unsigned MaxDh  = (DEBOUNCE_CYCLES > HIGH_CYCLES) ? DEBOUNCE_CYCLES : HIGH_CYCLES;
  localparam int unsigned MaxCyc = (MaxDh > RUN_HALF_PERIOD) ? MaxDh : RUN_HALF_PERIOD;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] HighLast = CntW'(HIGH_CYCLES - 1);
  localparam logic [CntW-1:0] RunLast  = CntW'(RUN_HALF_PERIOD - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StPressChk,
    StPulseHigh,
    StReleaseChk,
    StRunLow,
    StRunHigh
  } state_e;

  logic            btn_meta_q, btn_s_q;
  logic            run_meta_q, run_s_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            cycle_q;
  logic [4:0]      count_q;
  logic            busy_q;

  // Two-flop synchronizers for the asynchronous button and run switch.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
    end else begin
      btn_meta_q <= button;
      btn_s_q    <= btn_meta_q;
      run_meta_q <= run_en;
      run_s_q    <= run_meta_q;
    end
  end

  // Step FSM; cycle, count and busy are registered alongside the state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cycle_q <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // Run mode takes priority over a simultaneous button press.
          if (run_s_q) begin
            state_q <= StRunLow;
            busy_q  <= 1'b1;
          end else if (btn_s_q) begin
            state_q <= StPressChk;
            busy_q  <= 1'b1;
          end
        end
        StPressChk: begin
          if (!btn_s_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == DebLast) begin
            state_q <= StPulseHigh;
            cycle_q <= 1'b1;
            count_q <= count_q + 5'd1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPulseHigh: begin
          if (cnt_q == HighLast) begin
            state_q <= StReleaseChk;
            cycle_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StReleaseChk: begin
          // Any sign of the button still held restarts the release window.
          if (btn_s_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DebLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRunLow: begin
          if (cnt_q == RunLast) begin
            cnt_q <= '0;
            if (run_s_q) begin
              state_q <= StRunHigh;
              cycle_q <= 1'b1;
              count_q <= count_q + 5'd1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRunHigh: begin
          // run_s is ignored here so a high phase always runs full width.
          if (cnt_q == RunLast) begin
            state_q <= StRunLow;
            cycle_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          cycle_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cycle = cycle_q;
  assign count = count_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen with short debounce/pulse/run timings.
module tb_step_clock_gen;

  localparam int unsigned Deb  = 4;
  localparam int unsigned High = 2;
  localparam int unsigned Half = 3;

  logic       clock;
  logic       reset_n;
  logic       button;
  logic       run_en;
  logic       cycle;
  logic [4:0] count;
  logic       busy;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(Deb),
    .HIGH_CYCLES    (High),
    .RUN_HALF_PERIOD(Half)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .button (button),
    .run_en (run_en),
    .cycle  (cycle),
    .count  (count),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_bad;

  // Reference model: phase plus a countdown of clocks still required.
  typedef enum int {PhIdle, PhPress, PhPulse, PhRelease, PhLow, PhHigh} phase_t;
  phase_t ph;
  int     left;
  int     m_count;
  logic   m_bm, m_bs, m_rm, m_rs;

  // Observation of the DUT's cycle output.
  logic prev_cycle;
  int   n_rise;
  int   hi_run;
  int   last_high_len;
  bit   use_model;

  typedef struct {
    logic       btn;
    logic       rst_n;
    logic       e_cycle;
    logic [4:0] e_count;
    logic       e_busy;
  } vec_t;
  vec_t tbl[30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic bs, rs;
    if (!reset_n) begin
      ph = PhIdle; left = 0; m_count = 0;
      m_bm = 0; m_bs = 0; m_rm = 0; m_rs = 0;
      return;
    end
    bs = m_bs;
    rs = m_rs;
    case (ph)
      PhIdle: begin
        if (rs) begin ph = PhLow; left = Half; end
        else if (bs) begin ph = PhPress; left = Deb; end
      end
      PhPress: begin
        if (!bs) ph = PhIdle;
        else if (left == 1) begin ph = PhPulse; left = High; m_count = (m_count + 1) % 32; end
        else left--;
      end
      PhPulse: begin
        if (left == 1) begin ph = PhRelease; left = Deb; end
        else left--;
      end
      PhRelease: begin
        if (bs) left = Deb;
        else if (left == 1) ph = PhIdle;
        else left--;
      end
      PhLow: begin
        if (left == 1) begin
          if (rs) begin ph = PhHigh; left = Half; m_count = (m_count + 1) % 32; end
          else ph = PhIdle;
        end else left--;
      end
      PhHigh: begin
        if (left == 1) begin ph = PhLow; left = Half; end
        else left--;
      end
      default: ph = PhIdle;
    endcase
    m_bs = m_bm; m_bm = button;
    m_rs = m_rm; m_rm = run_en;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    if (cycle === 1'b1 && prev_cycle !== 1'b1) n_rise++;
    if (cycle === 1'b1) hi_run++;
    else if (prev_cycle === 1'b1) begin last_high_len = hi_run; hi_run = 0; end
    prev_cycle = cycle;
    if (use_model) begin
      chk("cycle", cycle, (ph == PhPulse || ph == PhHigh) ? 1 : 0);
      chk("count", count, m_count);
      chk("busy",  busy,  (ph != PhIdle) ? 1 : 0);
    end
  endtask

  task automatic hold(input logic b, input logic r, input int n);
    button = b;
    run_en = r;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int c0;
    int start_count;
    int budget;
    int seg_len;

    n_cmp = 0; n_bad = 0;
    n_rise = 0; hi_run = 0; last_high_len = 0; prev_cycle = 1'b0;
    ph = PhIdle; left = 0; m_count = 0;
    m_bm = 0; m_bs = 0; m_rm = 0; m_rs = 0;
    use_model = 1'b1;
    reset_n = 1'b0; button = 1'b0; run_en = 1'b0;

    // Initial reset: everything idle and zero.
    for (int i = 0; i < 3; i++) tick();
    chk("reset_cycle", cycle, 0);
    chk("reset_count", count, 0);
    chk("reset_busy",  busy,  0);

    // Reset held with button pressed, then a clean 20-clock press.
    // Edge k counts from the first non-reset edge that samples button=1.
    for (int i = 0; i < 2; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0};
    for (int k = 1; k <= 28; k++) begin
      tbl[k+1].btn     = (k <= 20);
      tbl[k+1].rst_n   = 1'b1;
      tbl[k+1].e_cycle = (k == 7 || k == 8);
      tbl[k+1].e_count = (k >= 7) ? 5'd1 : 5'd0;
      tbl[k+1].e_busy  = (k >= 3 && k <= 25);
    end
    use_model = 1'b0;
    for (int i = 0; i < 30; i++) begin
      button  = tbl[i].btn;
      reset_n = tbl[i].rst_n;
      tick();
      chk($sformatf("tbl%0d_cycle", i), cycle, tbl[i].e_cycle);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
      chk($sformatf("tbl%0d_busy",  i), busy,  tbl[i].e_busy);
    end
    use_model = 1'b1;

    // Bounce: toggling never qualifies; settled press gives one 2-clock pulse.
    c0 = n_rise;
    for (int i = 0; i < 8; i++) hold(((i % 2) == 0), 1'b0, 1);
    chk("bounce_no_pulse", n_rise, c0);
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 10);
    chk("bounce_one_pulse", n_rise, c0 + 1);
    chk("bounce_width", last_high_len, High);
    chk("bounce_count", count, 2);

    // Long hold with a short release glitch: still a single pulse.
    c0 = n_rise;
    hold(1'b1, 1'b0, 50);
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 20);
    chk("hold_single", n_rise, c0 + 1);
    chk("hold_busy", busy, 1);
    hold(1'b0, 1'b0, 10);
    chk("hold_idle", busy, 0);
    hold(1'b1, 1'b0, 15);
    hold(1'b0, 1'b0, 10);
    chk("repress_second", n_rise, c0 + 2);
    chk("repress_count", count, 4);

    // Run mode for 40 clocks; run_en drops during a high phase.
    c0 = n_rise;
    hold(1'b0, 1'b1, 40);
    hold(1'b0, 1'b0, 20);
    chk("run_rises", n_rise, c0 + 7);
    chk("run_last_high", last_high_len, Half);
    chk("run_idle", busy, 0);
    chk("run_count", count, 11);

    // 32 steps wrap count back to its starting value, then reset mid-pulse.
    start_count = m_count;
    c0 = n_rise;
    button = 1'b0;
    run_en = 1'b1;
    budget = 0;
    while (n_rise < c0 + 32 && budget < 32 * 2 * Half + 40) begin
      tick();
      budget++;
    end
    chk("wrap_steps", n_rise, c0 + 32);
    chk("wrap_count", count, start_count);
    chk("wrap_cycle_high", cycle, 1);
    run_en = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("midpulse_cycle", cycle, 0);
    chk("midpulse_count", count, 0);
    chk("midpulse_busy",  busy,  0);
    reset_n = 1'b1;
    hold(1'b0, 1'b0, 4);

    // Randomised segments against the reference model.
    for (int s = 0; s < 300; s++) begin
      seg_len = $urandom_range(1, 14);
      reset_n = ($urandom_range(0, 49) != 0);
      button  = $urandom_range(0, 1);
      run_en  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < seg_len; i++) begin
        tick();
        reset_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
